bus_fifo: RTL and testbench
===========================

BUS_FIFO -- requirements
Module: bus_fifo

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits (1..16).
REQ-002 Parameter: ALMOST_FULL, default 12, level at or above which almostFull asserts (1..16).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: nReset  input  1  asynchronous, active-low reset.
REQ-005 Port: clear  input  1  synchronous flush of pointers, level and error flags.
REQ-006 Port: wrEn  input  1  write request.
REQ-007 Port: wrData  input  WIDTH  write data.
REQ-008 Port: rdEn  input  1  read request; pops the word currently on rdData.
REQ-009 Port: rdData  output  WIDTH  head-of-queue word (first-word-fall-through).
REQ-010 Port: level  output  5  number of stored words, 0..16.
REQ-011 Port: empty  output  1  level == 0.
REQ-012 Port: full  output  1  level == 16.
REQ-013 Port: almostFull  output  1  level >= ALMOST_FULL.
REQ-014 Port: overflow  output  1  sticky; a write was rejected.
REQ-015 Port: underflow  output  1  sticky; a read was rejected.
REQ-016 Port: errClear  input  1  synchronous clear of overflow/underflow only.

Function
REQ-017 Storage SHALL be 16 x WIDTH, single write port with synchronous write and an asynchronous read port, mappable one bit per 16x1 dual-port distributed RAM cell; storage SHALL have no reset.
REQ-018 Write and read pointers SHALL be 4 bits, wrapping 15 -> 0 with no other special case.
REQ-019 Write accepted iff wrEn && !full && !clear; accepted write stores wrData at wrPtr and increments wrPtr on that edge.
REQ-020 Read accepted iff rdEn && !empty && !clear; accepted read increments rdPtr on that edge.
REQ-021 rdData SHALL equal storage[rdPtr] combinationally; value is undefined while empty.
REQ-022 A word written on edge N SHALL be visible on rdData, with empty low, immediately after edge N (one-cycle write-to-read latency).
REQ-023 level: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-024 Full with wrEn and rdEn together: read accepted, write rejected, overflow set, level 16 -> 15.
REQ-025 Empty with wrEn and rdEn together: write accepted, read rejected, underflow set, level 0 -> 1.
REQ-026 wrEn while full (write rejected) SHALL set overflow; rdEn while empty (read rejected) SHALL set underflow; storage and pointers unchanged by rejected requests.
REQ-027 Flags empty, full, almostFull SHALL be decoded from registered level, no extra latency.
REQ-028 clear SHALL zero wrPtr, rdPtr, level, overflow, underflow on the next edge and override wrEn/rdEn/errClear in that cycle.
REQ-029 errClear SHALL zero overflow and underflow on the next edge; a rejection in the same cycle SHALL win (flag remains set).

Reset
REQ-030 nReset low SHALL immediately, independent of clk, force wrPtr = 0, rdPtr = 0, level = 0, empty = 1, full = 0, almostFull = 0, overflow = 0, underflow = 0.
REQ-031 rdData after reset SHALL be don't-care; storage contents SHALL NOT be relied on.
REQ-032 nReset asserted mid-transfer SHALL discard all queued words; first write after release SHALL be the first word read.

Verification
REQ-033 Fill/drain: write 0x01..0x10 (16 words) -> full = 1, level = 16, almostFull high from 12th write; read 16 -> rdData sequence 0x01..0x10, empty = 1.
REQ-034 Wrap: write 10, read 10, write 16 values 0xA0..0xAF -> read order 0xA0..0xAF exactly, no loss across pointer wrap.
REQ-035 Boundary simultaneity: at level 16 assert wrEn+rdEn with wrData 0x55 -> level 15, overflow = 1, 0x55 never read; at level 0 assert both with 0x33 -> level 1, underflow = 1, rdData = 0x33 next cycle.
REQ-036 FWFT latency: from empty, single write 0x7E -> empty low and rdData = 0x7E on first cycle after the write edge.
REQ-037 Clear priority: level 5, assert clear with wrEn+rdEn -> level 0, empty = 1, flags 0; errClear with simultaneous rejected read -> underflow stays 1.
REQ-038 Async reset: assert nReset between clock edges at level 9 with overflow set -> outputs at reset values before next edge; write 0x42 after release -> rdData = 0x42.

Source files
------------

// File: rtl/bus_fifo.sv
// 16-deep first-word-fall-through FIFO with sticky overflow/underflow flags.
// Storage is unreset distributed RAM; all control state resets asynchronously.
module bus_fifo #(
  parameter int WIDTH       = 8,
  parameter int ALMOST_FULL = 12
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             clear,
  input  logic             errClear,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic [4:0]       level,
  output logic             empty,
  output logic             full,
  output logic             almostFull,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [16];
  logic [3:0]       wr_ptr;
  logic [3:0]       rd_ptr;
  logic [4:0]       level_q;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_reject;
  logic             rd_reject;

  assign empty      = (level_q == 5'd0);
  assign full       = (level_q == 5'd16);
  assign almostFull = (level_q >= 5'(ALMOST_FULL));
  assign level      = level_q;

  // clear masks both requests, so a flush cycle neither stores nor flags anything
  assign wr_ok     = wrEn && !full  && !clear;
  assign rd_ok     = rdEn && !empty && !clear;
  assign wr_reject = wrEn && full   && !clear;
  assign rd_reject = rdEn && empty  && !clear;

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wrData;
  end

  assign rdData = mem[rd_ptr];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr    <= 4'd0;
      rd_ptr    <= 4'd0;
      level_q   <= 5'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= 4'd0;
      rd_ptr    <= 4'd0;
      level_q   <= 5'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 4'd1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 4'd1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
      // a rejection in the same cycle as errClear keeps the flag set
      overflow  <= wr_reject || (overflow  && !errClear);
      underflow <= rd_reject || (underflow && !errClear);
    end
  end

endmodule

// File: tb/tb_bus_fifo.sv
// Directed self-checking bench for bus_fifo: fill/drain, wrap, boundary
// simultaneity, FWFT latency, clear priority and asynchronous reset.
module tb_bus_fifo;

  logic       clk = 1'b0;
  logic       nReset;
  logic       clear;
  logic       errClear;
  logic       wrEn;
  logic [7:0] wrData;
  logic       rdEn;
  logic [7:0] rdData;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almostFull;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fails  = 0;

  bus_fifo #(.WIDTH(8), .ALMOST_FULL(12)) dut (
    .clk(clk), .nReset(nReset), .clear(clear), .errClear(errClear),
    .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn), .rdData(rdData),
    .level(level), .empty(empty), .full(full), .almostFull(almostFull),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wrEn = 1'b1; wrData = d;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic pop();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; clear = 1'b0; errClear = 1'b0;
    wrEn = 1'b0; rdEn = 1'b0; wrData = 8'h00;
    tick(); tick();
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0 || almostFull !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_full got %b/%b want 0/0", full, almostFull); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_err got %b/%b want 0/0", overflow, underflow); end
    @(negedge clk);
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      n_checks++; if (level !== 5'(i)) begin n_fails++; $display("[TB] FAIL fill_level[%0d] got %0d want %0d", i, level, i); end
      n_checks++; if (almostFull !== (i >= 12)) begin n_fails++; $display("[TB] FAIL fill_almostFull[%0d] got %b want %b", i, almostFull, (i >= 12)); end
      n_checks++; if (full !== (i == 16)) begin n_fails++; $display("[TB] FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); end
    end
    for (int i = 1; i <= 16; i++) begin
      n_checks++; if (rdData !== 8'(i)) begin n_fails++; $display("[TB] FAIL drain_data[%0d] got %h want %h", i, rdData, 8'(i)); end
      pop();
    end
    n_checks++; if (empty !== 1'b1 || level !== 5'd0) begin n_fails++; $display("[TB] FAIL drain_empty got %b/%0d want 1/0", empty, level); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 10; i++) pop();
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    n_checks++; if (full !== 1'b1) begin n_fails++; $display("[TB] FAIL wrap_full got %b want 1", full); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (rdData !== 8'hA0 + 8'(i)) begin n_fails++; $display("[TB] FAIL wrap_data[%0d] got %h want %h", i, rdData, 8'hA0 + 8'(i)); end
      pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 16; i++) push(8'h60 + 8'(i));
    wrEn = 1'b1; rdEn = 1'b1; wrData = 8'h55;
    tick();
    wrEn = 1'b0; rdEn = 1'b0;
    n_checks++; if (level !== 5'd15) begin n_fails++; $display("[TB] FAIL full_both_level got %0d want 15", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL full_both_overflow got %b want 1", overflow); end
    for (int i = 2; i <= 16; i++) begin
      n_checks++; if (rdData !== 8'h60 + 8'(i)) begin n_fails++; $display("[TB] FAIL full_both_data[%0d] got %h want %h", i, rdData, 8'h60 + 8'(i)); end
      pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL full_both_empty got %b want 1", empty); end
    wrEn = 1'b1; rdEn = 1'b1; wrData = 8'h33;
    tick();
    wrEn = 1'b0; rdEn = 1'b0;
    n_checks++; if (level !== 5'd1) begin n_fails++; $display("[TB] FAIL empty_both_level got %0d want 1", level); end
    n_checks++; if (underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL empty_both_underflow got %b want 1", underflow); end
    n_checks++; if (rdData !== 8'h33) begin n_fails++; $display("[TB] FAIL empty_both_data got %h want 33", rdData); end
    pop();
  endtask

  task automatic test_fwft();
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL errclear got %b/%b want 0/0", overflow, underflow); end
    push(8'h7E);
    n_checks++; if (empty !== 1'b0) begin n_fails++; $display("[TB] FAIL fwft_empty got %b want 0", empty); end
    n_checks++; if (rdData !== 8'h7E) begin n_fails++; $display("[TB] FAIL fwft_data got %h want 7e", rdData); end
    pop();
  endtask

  task automatic test_clear();
    pop();
    n_checks++; if (underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL clear_pre_underflow got %b want 1", underflow); end
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    n_checks++; if (level !== 5'd5) begin n_fails++; $display("[TB] FAIL clear_pre_level got %0d want 5", level); end
    clear = 1'b1; wrEn = 1'b1; rdEn = 1'b1; wrData = 8'hEE;
    tick();
    clear = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
    n_checks++; if (level !== 5'd0 || empty !== 1'b1) begin n_fails++; $display("[TB] FAIL clear_level got %0d/%b want 0/1", level, empty); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_flags got %b/%b want 0/0", overflow, underflow); end
    errClear = 1'b1; rdEn = 1'b1;
    tick();
    errClear = 1'b0; rdEn = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL errclear_vs_reject got %b want 1", underflow); end
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    n_checks++; if (underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL errclear_alone got %b want 0", underflow); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    push(8'hFF);
    for (int i = 0; i < 7; i++) pop();
    n_checks++; if (level !== 5'd9 || overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL areset_pre got %0d/%b want 9/1", level, overflow); end
    #2;
    nReset = 1'b0;
    #1;
    n_checks++; if (level !== 5'd0 || empty !== 1'b1) begin n_fails++; $display("[TB] FAIL areset_level got %0d/%b want 0/1", level, empty); end
    n_checks++; if (full !== 1'b0 || almostFull !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL areset_flags got %b%b%b%b want 0000", full, almostFull, overflow, underflow); end
    @(negedge clk);
    nReset = 1'b1;
    tick();
    push(8'h42);
    n_checks++; if (rdData !== 8'h42 || level !== 5'd1) begin n_fails++; $display("[TB] FAIL areset_first got %h/%0d want 42/1", rdData, level); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_fwft();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
